// File: rtl/bcd2counter_pkg.sv
// Shared constants, state encoding and small helpers for the BCD date/time to
// Unix-seconds converter.
package bcd2counter_pkg;

    localparam int UNIX_EPOCH_YEAR    = 1970;
    localparam int LEAPS_BEFORE_EPOCH = 477;
    localparam int SECS_PER_DAY       = 86400;
    localparam int SECS_PER_HOUR      = 3600;
    localparam int SECS_PER_MIN       = 60;
    localparam int DAYS_PER_YEAR      = 365;

    // Index 0 is January; entries are listed December first.
    localparam logic [11:0][8:0] CUM_DAYS = {
        9'd334, 9'd304, 9'd273, 9'd243, 9'd212, 9'd181,
        9'd151, 9'd120, 9'd90,  9'd59,  9'd31,  9'd0
    };

    localparam logic [11:0][4:0] MONTH_LEN = {
        5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31,
        5'd30, 5'd31, 5'd30, 5'd31, 5'd28, 5'd31
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BCD,
        ST_CHECK,
        ST_DIV,
        ST_DAYS,
        ST_SECS,
        ST_DONE
    } state_t;

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic nibbles_bad(input logic [7:0] b);
        return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

    // Multiply by a constant as a sum of shifted copies; k folds away in synthesis.
    function automatic logic [63:0] mul_const(input logic [63:0] x, input logic [31:0] k);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (k[i]) acc = acc + (x << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd2counter_seq_div14.sv
// 14-bit restoring divider: one quotient bit per cycle, 14 cycles per division.
module seq_div14 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] dividend,
    input  logic [13:0] divisor,
    output logic [13:0] quotient,
    output logic        done
);

    logic [13:0] rem_q, quo_q, dvsr_q;
    logic [3:0]  cnt_q;
    logic        run_q;

    logic [13:0] src_rem, src_quo, src_dvsr, nrem, nquo;
    logic [14:0] trial;
    logic        fits;

    // The first iteration runs in the start cycle straight from the inputs.
    always_comb begin
        src_rem  = start ? 14'd0    : rem_q;
        src_quo  = start ? dividend : quo_q;
        src_dvsr = start ? divisor  : dvsr_q;
        trial    = {src_rem, src_quo[13]};
        fits     = trial >= {1'b0, src_dvsr};
        nrem     = fits ? 14'(trial - {1'b0, src_dvsr}) : trial[13:0];
        nquo     = {src_quo[12:0], fits};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= 4'd0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= 4'd1;
        end else if (run_q) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd13) run_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start || run_q) begin
            rem_q <= nrem;
            quo_q <= nquo;
        end
        if (start) dvsr_q <= divisor;
    end

    // High during the final iteration; quotient is valid from the next cycle.
    assign done     = run_q && (cnt_q == 4'd13);
    assign quotient = quo_q;

endmodule

// File: rtl/bcd2counter.sv
// Validates a BCD calendar date/time (UTC) and converts it to Unix seconds
// with a fixed-latency multi-cycle datapath.
module bcd2counter
    import bcd2counter_pkg::*;
#(
    parameter int YEAR_MIN = 1970,
    parameter int YEAR_MAX = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] year_bcd,
    input  logic [7:0]  month_bcd,
    input  logic [7:0]  day_bcd,
    input  logic [7:0]  hour_bcd,
    input  logic [7:0]  minute_bcd,
    input  logic [7:0]  second_bcd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] counter
);

    state_t state, state_next;

    logic [15:0] year_r;
    logic [7:0]  month_r, day_r, hour_r, minute_r, second_r;

    logic [13:0] year_bin;
    logic [6:0]  yy_bin, month_bin, day_bin, hour_bin, minute_bin, second_bin;
    logic [1:0]  cc_mod4;
    logic        nib_bad;
    logic [6:0]  cc_c, yy_c;

    logic        leap_q, err_q;
    logic [3:0]  midx_q;
    logic [1:0]  div_idx;
    logic        div_kick;
    logic [13:0] q4, q100;
    logic [63:0] days_q;

    logic        div_start, div_done;
    logic [13:0] div_divisor, div_quotient;

    logic        leap_c, month_ok, year_ok, day_ok, time_ok, check_ok, feb_extra;
    logic [3:0]  midx_c;
    logic [6:0]  mlen_c;
    logic [63:0] days_c, secs_c;

    assign cc_c = bcd_to_bin(year_r[15:8]);
    assign yy_c = bcd_to_bin(year_r[7:0]);

    // Leap test works on the BCD halves: yy picks the rule, cc decides centuries.
    always_comb begin
        leap_c   = (yy_bin != 7'd0) ? (yy_bin[1:0] == 2'd0) : (cc_mod4 == 2'd0);
        month_ok = (month_bin >= 7'd1) && (month_bin <= 7'd12);
        midx_c   = month_ok ? (month_bin[3:0] - 4'd1) : 4'd0;
        mlen_c   = 7'(MONTH_LEN[midx_c]) + 7'((midx_c == 4'd1) && leap_c);
        year_ok  = (32'(year_bin) >= 32'(YEAR_MIN)) && (32'(year_bin) <= 32'(YEAR_MAX));
        day_ok   = (day_bin != 7'd0) && (day_bin <= mlen_c);
        time_ok  = (hour_bin <= 7'd23) && (minute_bin <= 7'd59) && (second_bin <= 7'd59);
        check_ok = !nib_bad && year_ok && month_ok && day_ok && time_ok;
    end

    always_comb begin
        feb_extra = (month_bin > 7'd2) && leap_q;
        days_c = mul_const(64'(year_bin) - 64'(UNIX_EPOCH_YEAR), 32'(DAYS_PER_YEAR))
               + 64'(q4) - 64'(q100) + 64'(div_quotient) - 64'(LEAPS_BEFORE_EPOCH)
               + 64'(CUM_DAYS[midx_q]) + 64'(feb_extra) + 64'(day_bin) - 64'd1;
        secs_c = mul_const(days_q, 32'(SECS_PER_DAY))
               + mul_const(64'(hour_bin), 32'(SECS_PER_HOUR))
               + mul_const(64'(minute_bin), 32'(SECS_PER_MIN))
               + 64'(second_bin);
    end

    always_comb begin
        unique case (div_idx)
            2'd0:    div_divisor = 14'd4;
            2'd1:    div_divisor = 14'd100;
            default: div_divisor = 14'd400;
        endcase
    end

    assign div_start = (state == ST_DIV) && div_kick;

    seq_div14 u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (year_bin - 14'd1),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_BCD;
            ST_BCD:   state_next = ST_CHECK;
            ST_CHECK: state_next = check_ok ? ST_DIV : ST_DONE;
            ST_DIV:   if (div_done && (div_idx == 2'd2)) state_next = ST_DAYS;
            ST_DAYS:  state_next = ST_SECS;
            ST_SECS:  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_idx  <= 2'd0;
            div_kick <= 1'b0;
            err_q    <= 1'b0;
            counter  <= 64'd0;
        end else begin
            case (state)
                ST_CHECK: begin
                    err_q <= !check_ok;
                    if (check_ok) begin
                        div_kick <= 1'b1;
                        div_idx  <= 2'd0;
                    end
                end
                ST_DIV: begin
                    if (div_kick) div_kick <= 1'b0;
                    if (div_done) begin
                        div_idx  <= div_idx + 2'd1;
                        div_kick <= (div_idx != 2'd2);
                    end
                end
                ST_SECS: counter <= secs_c;
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; every use is gated by the FSM.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && start) begin
            year_r   <= year_bcd;
            month_r  <= month_bcd;
            day_r    <= day_bcd;
            hour_r   <= hour_bcd;
            minute_r <= minute_bcd;
            second_r <= second_bcd;
        end
        if (state == ST_BCD) begin
            year_bin   <= 14'(cc_c) * 14'd100 + 14'(yy_c);
            yy_bin     <= yy_c;
            cc_mod4    <= cc_c[1:0];
            month_bin  <= bcd_to_bin(month_r);
            day_bin    <= bcd_to_bin(day_r);
            hour_bin   <= bcd_to_bin(hour_r);
            minute_bin <= bcd_to_bin(minute_r);
            second_bin <= bcd_to_bin(second_r);
            nib_bad    <= nibbles_bad(year_r[15:8]) | nibbles_bad(year_r[7:0])
                        | nibbles_bad(month_r) | nibbles_bad(day_r)
                        | nibbles_bad(hour_r) | nibbles_bad(minute_r)
                        | nibbles_bad(second_r);
        end
        if (state == ST_CHECK) begin
            leap_q <= leap_c;
            midx_q <= midx_c;
        end
        // A new division starts the cycle after the previous quotient settles.
        if ((state == ST_DIV) && div_kick) begin
            if (div_idx == 2'd1) q4   <= div_quotient;
            if (div_idx == 2'd2) q100 <= div_quotient;
        end
        if (state == ST_DAYS) days_q <= days_c;
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign err  = done && err_q;

endmodule
